instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC sequencing with one delay slot per redirect,
// stall-deferred redirects, halt on PC zero and fault on misaligned targets.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_target,
    output logic [31:0]        instr_addr,
    input  logic [31:0]        instr_in,
    output logic               fetch_valid,
    output logic [31:0]        fetch_instr,
    output logic [31:0]        fetch_pc,
    output logic               active,
    output logic               fault,
    output logic [COUNT_W-1:0] fetch_count
);

    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nx;
    logic [ADDR_W-1:0]   r_pending;
    logic [ADDR_W-1:0]   w_pending_nx;
    logic                r_fetch_valid;
    logic [ADDR_W-1:0]   r_fetch_instr;
    logic [ADDR_W-1:0]   r_fetch_pc;
    logic                r_active;
    logic                w_active_nx;
    logic                r_fault;
    logic                w_fault_nx;
    logic [COUNT_W-1:0]  r_count;
    logic                w_deliver;
    logic                w_pc_zero;

    assign instr_addr  = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign fetch_instr = r_fetch_instr;
    assign fetch_pc    = r_fetch_pc;
    assign active      = r_active;
    assign fault       = r_fault;
    assign fetch_count = r_count;

    assign w_pc_zero = (r_pc == '0);

    // State, PC and fetch output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pc          <= RESET_VECTOR;
            r_pending     <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_instr <= '0;
            r_fetch_pc    <= '0;
            r_active      <= 1'b1;
            r_fault       <= 1'b0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_pc          <= w_pc_nx;
            r_pending     <= w_pending_nx;
            r_fetch_valid <= w_deliver;
            r_active      <= w_active_nx;
            r_fault       <= w_fault_nx;
            if (w_deliver) begin
                r_fetch_instr <= instr_in;
                r_fetch_pc    <= r_pc;
                if (r_count != '1) begin
                    r_count <= r_count + COUNT_W'(1);
                end
            end
        end
    end

    // Next-state, next-PC and delivery decision
    always_comb begin
        w_state_nx   = r_state;
        w_pc_nx      = r_pc;
        w_pending_nx = r_pending;
        w_fault_nx   = r_fault;
        w_deliver    = 1'b0;

        case (r_state)
            RUN: begin
                if (!stall) begin
                    if (w_pc_zero) begin
                        w_state_nx = HALT;
                    end else begin
                        w_deliver = 1'b1;
                        if (redirect_valid) begin
                            // Current fetch is the delay slot
                            w_pc_nx = redirect_target;
                            if (redirect_target[1:0] != 2'b00) begin
                                w_state_nx = FAULT;
                                w_fault_nx = 1'b1;
                            end
                        end else begin
                            w_pc_nx = r_pc + ADDR_W'(4);
                        end
                    end
                end else if (redirect_valid && !w_pc_zero) begin
                    w_pending_nx = redirect_target;
                    w_state_nx   = PEND;
                end
            end
            PEND: begin
                if (!stall) begin
                    w_deliver = !w_pc_zero;
                    w_pc_nx   = r_pending;
                    if (r_pending[1:0] != 2'b00) begin
                        w_state_nx = FAULT;
                        w_fault_nx = 1'b1;
                    end else begin
                        w_state_nx = RUN;
                    end
                end
            end
            HALT:    w_state_nx = HALT;
            FAULT:   w_state_nx = FAULT;
            default: w_state_nx = RUN;
        endcase

        w_active_nx = (w_state_nx == RUN) || (w_state_nx == PEND);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/100ps
module tb_instr_fetch_unit;

    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          redirect_valid;
    logic [31:0]   redirect_target;
    logic [31:0]   instr_addr;
    logic [31:0]   instr_in;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic [31:0]   fetch_pc;
    logic          active;
    logic          fault;
    logic [CW-1:0] fetch_count;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit #(.RESET_VECTOR(32'hBFC00000), .COUNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .instr_addr     (instr_addr),
        .instr_in       (instr_in),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_pc       (fetch_pc),
        .active         (active),
        .fault          (fault),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h13579BDF;
    endfunction

    assign instr_in = mem(instr_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: program-order view. mode 0=fetching, 1=waiting to jump, 2=halted, 3=faulted.
    int          m_mode;
    logic [31:0] m_pc, m_target, m_instr, m_fpc;
    logic        m_valid;
    int          m_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pc = 32'hBFC00000; m_target = 0;
            m_instr = 0; m_fpc = 0; m_valid = 0; m_count = 0;
        end else begin
            m_valid = (m_mode < 2) && !stall && (m_pc != 0);
            if (m_valid) begin
                m_instr = mem(m_pc);
                m_fpc   = m_pc;
                m_count = (m_count == (1 << CW) - 1) ? m_count : m_count + 1;
            end
            if (m_mode == 0) begin
                if (m_pc == 0) begin
                    if (!stall) m_mode = 2;
                end else if (stall) begin
                    if (redirect_valid) begin m_target = redirect_target; m_mode = 1; end
                end else if (redirect_valid) begin
                    m_pc = redirect_target;
                    if (m_pc % 4 != 0) m_mode = 3;
                end else begin
                    m_pc = m_pc + 4;
                end
            end else if (m_mode == 1 && !stall) begin
                m_pc   = m_target;
                m_mode = (m_pc % 4 != 0) ? 3 : 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_addr",  instr_addr, m_pc);
            chk("m_valid", 32'(fetch_valid), 32'(m_valid));
            chk("m_instr", fetch_instr, m_instr);
            chk("m_fpc",   fetch_pc, m_fpc);
            chk("m_active", 32'(active), 32'(m_mode < 2));
            chk("m_fault", 32'(fault), 32'(m_mode == 3));
            chk("m_count", 32'(fetch_count), 32'(m_count));
        end
    end

    task automatic cycle(input logic s, input logic rv, input logic [31:0] t);
        stall = s; redirect_valid = rv; redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_addr",  instr_addr, 32'hBFC00000);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_instr", fetch_instr, 32'd0);
        chk("rst_fpc",   fetch_pc, 32'd0);
        chk("rst_active", 32'(active), 32'd1);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 0;
        #1 rst_n = 1'b0;
        #11 rst_n = 1'b1;
        #1 chk("init_addr", instr_addr, 32'hBFC00000);

        // Sequential fetch and first redirect
        cycle(0, 0, 0);
        chk("seq1_fpc", fetch_pc, 32'hBFC00000);
        chk("seq1_addr", instr_addr, 32'hBFC00004);
        cycle(0, 0, 0);
        chk("seq2_fpc", fetch_pc, 32'hBFC00004);
        chk("seq2_valid", 32'(fetch_valid), 32'd1);
        chk("seq2_count", 32'(fetch_count), 32'd2);
        chk("seq2_addr", instr_addr, 32'hBFC00008);
        cycle(0, 1, 32'hBFC00100);
        chk("ds_fpc", fetch_pc, 32'hBFC00008);
        chk("ds_instr", fetch_instr, 32'hBFC00008 ^ 32'h13579BDF);
        chk("ds_addr", instr_addr, 32'hBFC00100);
        cycle(0, 1, 32'hBFC00010);

        // Redirect under stall, extra redirects ignored
        cycle(1, 1, 32'hBFC00200);
        chk("pend_addr", instr_addr, 32'hBFC00010);
        chk("pend_valid", 32'(fetch_valid), 32'd0);
        cycle(1, 1, 32'hBFC00300);
        cycle(1, 0, 0);
        chk("pend3_addr", instr_addr, 32'hBFC00010);
        cycle(0, 1, 32'hBFC00400);
        chk("rel_fpc", fetch_pc, 32'hBFC00010);
        chk("rel_addr", instr_addr, 32'hBFC00200);
        chk("rel_count", 32'(fetch_count), 32'd5);
        cycle(0, 0, 0);
        chk("after_fpc", fetch_pc, 32'hBFC00200);
        cycle(1, 0, 0);
        chk("stall_valid", 32'(fetch_valid), 32'd0);
        chk("stall_addr", instr_addr, 32'hBFC00204);

        // Redirect to zero halts
        cycle(0, 1, 32'h0);
        chk("z_fpc", fetch_pc, 32'hBFC00204);
        chk("z_addr", instr_addr, 32'h0);
        chk("z_active", 32'(active), 32'd1);
        cycle(0, 0, 0);
        chk("halt_active", 32'(active), 32'd0);
        chk("halt_valid", 32'(fetch_valid), 32'd0);
        cycle(0, 1, 32'hBFC00000);
        chk("halt_count", 32'(fetch_count), 32'd7);
        chk("halt_addr", instr_addr, 32'h0);

        // Misaligned redirect faults
        reset_pulse();
        cycle(0, 1, 32'hBFC00102);
        chk("f_fpc", fetch_pc, 32'hBFC00000);
        chk("f_fault", 32'(fault), 32'd1);
        chk("f_active", 32'(active), 32'd0);
        cycle(0, 0, 0);
        chk("f_valid", 32'(fetch_valid), 32'd0);
        chk("f_addr", instr_addr, 32'hBFC00102);
        reset_pulse();

        // Misaligned redirect deferred by stall
        cycle(1, 1, 32'hBFC00006);
        cycle(0, 0, 0);
        chk("pf_fpc", fetch_pc, 32'hBFC00000);
        chk("pf_fault", 32'(fault), 32'd1);
        chk("pf_addr", instr_addr, 32'hBFC00006);
        reset_pulse();

        // Address wrap to zero, then halt
        cycle(0, 1, 32'hFFFFFFFC);
        cycle(0, 0, 0);
        chk("wrap_fpc", fetch_pc, 32'hFFFFFFFC);
        chk("wrap_addr", instr_addr, 32'h0);
        cycle(0, 0, 0);
        chk("wrap_active", 32'(active), 32'd0);
        reset_pulse();

        // Counter saturation
        for (int i = 0; i < 20; i++) cycle(0, 0, 0);
        chk("sat_count", 32'(fetch_count), 32'd15);
        chk("sat_addr", instr_addr, 32'hBFC00050);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
